// File: rtl/commit_retire_unit_pkg.sv
// ============================================================================
// Module  : commit_retire_unit_pkg
// Brief   : Shared types and default sizes for the commit/retire unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package commit_retire_unit_pkg;

   localparam int unsigned C_COMMIT_WIDTH      = 2;
   localparam int unsigned C_PHY_REG_NUM_WIDTH = 7;
   localparam int unsigned C_LOG_REG_NUM_WIDTH = 5;
   localparam int unsigned C_PC_WIDTH          = 32;
   localparam int unsigned C_COUNT_WIDTH       = 32;

   typedef enum logic [1:0] {
      NORMAL       = 2'd0,
      RECOVER_WAIT = 2'd1,
      HALTED       = 2'd2
   } phase_t;

   typedef struct packed {
      logic                           valid;
      logic                           executed;
      logic                           writeReg;
      logic [C_PHY_REG_NUM_WIDTH-1:0] phyPrevDst;
      logic [C_LOG_REG_NUM_WIDTH-1:0] logDst;
      logic                           isLoad;
      logic                           isStore;
      logic                           isEnv;
      logic                           undefined;
      logic                           last;
      logic [C_PC_WIDTH-1:0]          pc;
   } commit_head_entry_t;

   // A one-slot head still needs a one-bit index.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/commit_retire_unit_selector.sv
// ============================================================================
// Module  : commit_retire_unit_selector
// Brief   : Combinational retire-prefix selection with stop conditions.
// Revision: 1.0
// ============================================================================
`default_nettype none

module commit_retire_unit_selector
   import commit_retire_unit_pkg::*;
#(
   parameter int unsigned COMMIT_WIDTH = C_COMMIT_WIDTH,
   parameter int unsigned IDX_W        = idx_width(C_COMMIT_WIDTH)
) (
   input  logic                    i_enable,
   input  logic [COMMIT_WIDTH-1:0] i_valid,
   input  logic [COMMIT_WIDTH-1:0] i_executed,
   input  logic [COMMIT_WIDTH-1:0] i_env,
   input  logic [COMMIT_WIDTH-1:0] i_undefined,
   input  logic [COMMIT_WIDTH-1:0] i_last,
   output logic [COMMIT_WIDTH-1:0] o_pop,
   output logic                    o_undef_valid,
   output logic [IDX_W-1:0]        o_undef_idx,
   output logic                    o_last_retired,
   output logic                    o_protocol_err
);

   logic [COMMIT_WIDTH-1:0] w_pop_raw;
   logic [COMMIT_WIDTH-1:0] w_valid_inc;
   logic [IDX_W-1:0]        w_undef_idx_raw;
   logic                    w_undef_hit;
   logic                    w_last_hit;
   logic                    w_stop;
   logic                    w_contig;
   logic                    w_go;

   // A thermometer mask plus one has no bits in common with the mask.
   assign w_valid_inc = i_valid + COMMIT_WIDTH'(1);
   assign w_contig    = ((i_valid & w_valid_inc) == '0);
   assign w_go        = i_enable && w_contig;

   always_comb begin
      w_stop          = 1'b0;
      w_pop_raw       = '0;
      w_undef_hit     = 1'b0;
      w_undef_idx_raw = '0;
      w_last_hit      = 1'b0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         if (!w_stop) begin
            if (!(i_valid[i] && i_executed[i]) || (i_env[i] && (i != 0))) begin
               w_stop = 1'b1;
            end else begin
               w_pop_raw[i] = 1'b1;
               if (i_undefined[i]) begin
                  w_undef_hit     = 1'b1;
                  w_undef_idx_raw = IDX_W'(i);
               end
               if (i_last[i]) begin
                  w_last_hit = 1'b1;
               end
               if (i_env[i] || i_undefined[i] || i_last[i]) begin
                  w_stop = 1'b1;
               end
            end
         end
      end
   end

   assign o_pop          = w_go ? w_pop_raw : '0;
   assign o_undef_valid  = w_go && w_undef_hit;
   assign o_undef_idx    = w_undef_idx_raw;
   assign o_last_retired = w_go && w_last_hit;
   assign o_protocol_err = !w_contig;

endmodule

`default_nettype wire

// File: rtl/commit_retire_unit.sv
// ============================================================================
// Module  : commit_retire_unit
// Brief   : In-order retirement at the active-list head; perf counters are
//           built only when COMMIT_RETIRE_PERF_COUNTER_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module commit_retire_unit
   import commit_retire_unit_pkg::*;
#(
   parameter int unsigned COMMIT_WIDTH      = C_COMMIT_WIDTH,
   parameter int unsigned PHY_REG_NUM_WIDTH = C_PHY_REG_NUM_WIDTH,
   parameter int unsigned LOG_REG_NUM_WIDTH = C_LOG_REG_NUM_WIDTH,
   parameter int unsigned PC_WIDTH          = C_PC_WIDTH,
   parameter int unsigned COUNT_WIDTH       = C_COUNT_WIDTH
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [COMMIT_WIDTH-1:0]                 i_head_valid,
   input  logic [COMMIT_WIDTH-1:0]                 i_head_executed,
   input  logic [COMMIT_WIDTH-1:0]                 i_head_write_reg,
   input  logic [COMMIT_WIDTH*PHY_REG_NUM_WIDTH-1:0] i_head_phy_prev_dst,
   input  logic [COMMIT_WIDTH*LOG_REG_NUM_WIDTH-1:0] i_head_log_dst,
   input  logic [COMMIT_WIDTH-1:0]                 i_head_is_load,
   input  logic [COMMIT_WIDTH-1:0]                 i_head_is_store,
   input  logic [COMMIT_WIDTH-1:0]                 i_head_is_env,
   input  logic [COMMIT_WIDTH-1:0]                 i_head_undefined,
   input  logic [COMMIT_WIDTH-1:0]                 i_head_last,
   input  logic [COMMIT_WIDTH*PC_WIDTH-1:0]        i_head_pc,
   input  logic                                    i_recover_done,
   output logic [COMMIT_WIDTH-1:0]                 o_pop_head,
   output logic [COMMIT_WIDTH-1:0]                 o_free_reg_valid,
   output logic [COMMIT_WIDTH*PHY_REG_NUM_WIDTH-1:0] o_free_reg_num,
   output logic [COMMIT_WIDTH-1:0]                 o_release_load_queue,
   output logic [COMMIT_WIDTH-1:0]                 o_commit_store,
   output logic                                    o_recover_req,
   output logic [PC_WIDTH-1:0]                     o_recovered_pc,
   output logic                                    o_halted,
   output logic [COUNT_WIDTH-1:0]                  o_committed_count,
   output logic [COUNT_WIDTH-1:0]                  o_head_stall_count
);

   localparam int unsigned C_IDX_W = idx_width(COMMIT_WIDTH);

   phase_t                  r_phase;
   logic                    r_recover_req;
   logic [PC_WIDTH-1:0]     r_recovered_pc;
   logic                    r_halted;

   commit_head_entry_t      w_entry [COMMIT_WIDTH];
   logic [COMMIT_WIDTH-1:0] w_valid;
   logic [COMMIT_WIDTH-1:0] w_executed;
   logic [COMMIT_WIDTH-1:0] w_env;
   logic [COMMIT_WIDTH-1:0] w_undefined;
   logic [COMMIT_WIDTH-1:0] w_last;
   logic [COMMIT_WIDTH-1:0] w_unused_log_dst;
   logic [COMMIT_WIDTH-1:0] w_pop;
   logic [C_IDX_W-1:0]      w_undef_idx;
   logic                    w_undef_valid;
   logic                    w_last_retired;
   logic                    w_protocol_err;
   logic                    w_enable;

   generate
      for (genvar g = 0; g < COMMIT_WIDTH; g++) begin : g_slot
         assign w_entry[g].valid      = i_head_valid[g];
         assign w_entry[g].executed   = i_head_executed[g];
         assign w_entry[g].writeReg   = i_head_write_reg[g];
         assign w_entry[g].phyPrevDst = i_head_phy_prev_dst[g*PHY_REG_NUM_WIDTH +: PHY_REG_NUM_WIDTH];
         assign w_entry[g].logDst     = i_head_log_dst[g*LOG_REG_NUM_WIDTH +: LOG_REG_NUM_WIDTH];
         assign w_entry[g].isLoad     = i_head_is_load[g];
         assign w_entry[g].isStore    = i_head_is_store[g];
         assign w_entry[g].isEnv      = i_head_is_env[g];
         assign w_entry[g].undefined  = i_head_undefined[g];
         assign w_entry[g].last       = i_head_last[g];
         assign w_entry[g].pc         = i_head_pc[g*PC_WIDTH +: PC_WIDTH];

         assign w_valid[g]     = w_entry[g].valid;
         assign w_executed[g]  = w_entry[g].executed;
         assign w_env[g]       = w_entry[g].isEnv;
         assign w_undefined[g] = w_entry[g].undefined;
         assign w_last[g]      = w_entry[g].last;
         // Logical destination is carried for trace only.
         assign w_unused_log_dst[g] = ^w_entry[g].logDst;

         assign o_free_reg_valid[g]     = w_pop[g] && w_entry[g].writeReg && !w_entry[g].undefined;
         assign o_free_reg_num[g*PHY_REG_NUM_WIDTH +: PHY_REG_NUM_WIDTH] = w_entry[g].phyPrevDst;
         assign o_release_load_queue[g] = w_pop[g] && w_entry[g].isLoad;
         assign o_commit_store[g]       = w_pop[g] && w_entry[g].isStore && !w_entry[g].undefined;
      end
   endgenerate

   assign w_enable = (r_phase == NORMAL) && !rst;

   commit_retire_unit_selector #(
      .COMMIT_WIDTH (COMMIT_WIDTH),
      .IDX_W        (C_IDX_W)
   ) u_selector (
      .i_enable       (w_enable),
      .i_valid        (w_valid),
      .i_executed     (w_executed),
      .i_env          (w_env),
      .i_undefined    (w_undefined),
      .i_last         (w_last),
      .o_pop          (w_pop),
      .o_undef_valid  (w_undef_valid),
      .o_undef_idx    (w_undef_idx),
      .o_last_retired (w_last_retired),
      .o_protocol_err (w_protocol_err)
   );

   assign o_pop_head = w_pop;

   // Undefined wins over last on the same entry: recovery is checked first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase        <= NORMAL;
         r_recover_req  <= 1'b0;
         r_recovered_pc <= '0;
         r_halted       <= 1'b0;
      end else begin
         r_recover_req <= 1'b0;
         case (r_phase)
            NORMAL: begin
               if (w_undef_valid) begin
                  r_phase        <= RECOVER_WAIT;
                  r_recover_req  <= 1'b1;
                  r_recovered_pc <= w_entry[w_undef_idx].pc;
               end else if (w_last_retired) begin
                  r_phase  <= HALTED;
                  r_halted <= 1'b1;
               end
            end
            RECOVER_WAIT: begin
               if (i_recover_done) begin
                  r_phase <= NORMAL;
               end
            end
            HALTED: begin
               r_phase <= HALTED;
            end
            default: begin
               r_phase <= NORMAL;
            end
         endcase
      end
   end

   assign o_recover_req  = r_recover_req;
   assign o_recovered_pc = r_recovered_pc;
   assign o_halted       = r_halted;

   always @(posedge clk) begin
      if (!rst) begin
         assert (!w_protocol_err);
      end
   end

`ifdef COMMIT_RETIRE_PERF_COUNTER_EN
   logic [COUNT_WIDTH-1:0] r_committed_count;
   logic [COUNT_WIDTH-1:0] r_head_stall_count;
   logic [COUNT_WIDTH-1:0] w_pop_count;

   always_comb begin
      w_pop_count = '0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         w_pop_count = w_pop_count + COUNT_WIDTH'(w_pop[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_committed_count  <= '0;
         r_head_stall_count <= '0;
      end else begin
         r_committed_count <= r_committed_count + w_pop_count;
         if ((r_phase == NORMAL) && w_valid[0] && !w_executed[0]) begin
            r_head_stall_count <= r_head_stall_count + COUNT_WIDTH'(1);
         end
      end
   end

   assign o_committed_count  = r_committed_count;
   assign o_head_stall_count = r_head_stall_count;
`else
   assign o_committed_count  = '0;
   assign o_head_stall_count = '0;
`endif

endmodule

`default_nettype wire
